// File: rtl/adder_pkg.sv
// Shared constants and payload types for the full-adder family.
package adder_pkg;

    localparam int unsigned FA_MAX_WIDTH = 64;

    // Result of a single 1-bit full-adder cell: {carry, sum}.
    typedef struct packed {
        logic       carry;
        logic [0:0] sum;
    } fa_result_t;

endpackage : adder_pkg

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder; one link of the ripple-carry chain.
module full_adder_cell
    import adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s0,
    output logic c0
);

    fa_result_t res_c;

    // Sum is the three-way parity; carry propagates when exactly one operand is set.
    always_comb begin
        res_c.sum   = a ^ b ^ c_in;
        res_c.carry = (a & b) | (c_in & (a ^ b));
    end

    assign s0 = res_c.sum[0];
    assign c0 = res_c.carry;

endmodule : full_adder_cell

// File: rtl/full_adder_unit.sv
// Registered ripple-carry adder: {c0, s0} = a + b + c_in, one cycle after in_valid.
module full_adder_unit
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s0,
    output logic             c0,
    output logic             out_valid
);

    // Reject unsupported widths at elaboration.
    if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_width_check
        $error("full_adder_unit: WIDTH out of range 1..FA_MAX_WIDTH");
    end

    logic [WIDTH:0]   carry_c;
    logic [WIDTH-1:0] sum_c;

    assign carry_c[0] = c_in;

    // Ripple chain: each cell's carry-out feeds the next cell's carry-in.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .c_in (carry_c[i]),
            .s0   (sum_c[i]),
            .c0   (carry_c[i+1])
        );
    end

    logic [WIDTH-1:0] s0_q, s0_d;
    logic             c0_q, c0_d;
    logic             out_valid_q, out_valid_d;

    // Load a new result on in_valid, otherwise hold; valid tracks in_valid.
    always_comb begin
        s0_d        = s0_q;
        c0_d        = c0_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            s0_d = sum_c;
            c0_d = carry_c[WIDTH];
        end
    end

    // Output registers; reset wins over a same-edge operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q        <= '0;
            c0_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s0_q        <= s0_d;
            c0_q        <= c0_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s0        = s0_q;
    assign c0        = c0_q;
    assign out_valid = out_valid_q;

endmodule : full_adder_unit

// File: tb/tb_full_adder_unit.sv
// Self-checking bench: WIDTH=1, 4 and 8 instances against an arithmetic model.
module tb_full_adder_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=1 instance
    logic       a1 = 1'b0, b1 = 1'b0, ci1 = 1'b0, v1 = 1'b0;
    logic       s1, c1, ov1;
    // WIDTH=4 instance
    logic [3:0] a4 = '0, b4 = '0;
    logic       ci4 = 1'b0, v4 = 1'b0;
    logic [3:0] s4;
    logic       c4, ov4;
    // WIDTH=8 instance
    logic [7:0] a8 = '0, b8 = '0;
    logic       ci8 = 1'b0, v8 = 1'b0;
    logic [7:0] s8;
    logic       c8, ov8;

    full_adder_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .c_in(ci1),
        .s0(s1), .c0(c1), .out_valid(ov1));
    full_adder_unit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .c_in(ci4),
        .s0(s4), .c0(c4), .out_valid(ov4));
    full_adder_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .c_in(ci8),
        .s0(s8), .c0(c8), .out_valid(ov8));

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: registered {carry, sum} of plain integer addition.
    logic [1:0] m1;   logic m1_v;
    logic [4:0] m4;   logic m4_v;
    logic [8:0] m8;   logic m8_v;
    bit model_live = 1'b0;

    always @(posedge clk) begin
        model_live <= 1'b1;
        if (rst) begin
            m1 <= '0; m4 <= '0; m8 <= '0;
            m1_v <= 1'b0; m4_v <= 1'b0; m8_v <= 1'b0;
        end else begin
            if (v1) m1 <= 2'(a1) + 2'(b1) + 2'(ci1);
            if (v4) m4 <= 5'(a4) + 5'(b4) + 5'(ci4);
            if (v8) m8 <= 9'(a8) + 9'(b8) + 9'(ci8);
            m1_v <= v1; m4_v <= v4; m8_v <= v8;
        end
    end

    // Every cycle, compare all DUT outputs against the model.
    always @(negedge clk) begin
        if (model_live) begin
            check("w1_sum_carry", 64'({c1, s1}), 64'(m1));
            check("w1_valid",     64'(ov1),      64'(m1_v));
            check("w4_sum_carry", 64'({c4, s4}), 64'(m4));
            check("w4_valid",     64'(ov4),      64'(m4_v));
            check("w8_sum_carry", 64'({c8, s8}), 64'(m8));
            check("w8_valid",     64'(ov8),      64'(m8_v));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] tt_exp [8];

    initial begin
        tt_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        // Reset state
        rst = 1'b1;
        tick(); tick();
        check("reset_w1", 64'({c1, s1, ov1}), 64'd0);
        check("reset_w4", 64'({c4, s4, ov4}), 64'd0);
        check("reset_w8", 64'({c8, s8, ov8}), 64'd0);
        rst = 1'b0;

        // Exhaustive 1-bit truth table, back-to-back
        for (int i = 0; i < 8; i++) begin
            {a1, b1, ci1} = 3'(i);
            v1 = 1'b1;
            tick();
            check($sformatf("truth_%0d", i), 64'({c1, s1}), 64'(tt_exp[i]));
            check($sformatf("truth_valid_%0d", i), 64'(ov1), 64'd1);
        end

        // Reset discards a same-edge operation
        rst = 1'b1; a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1; v1 = 1'b1;
        tick();
        check("rst_over_valid", 64'({c1, s1, ov1}), 64'd0);
        rst = 1'b0;
        tick();
        check("rst_release", 64'({c1, s1, ov1}), 64'b111);

        // Hold while in_valid is low and inputs toggle
        a1 = 1'b1; b1 = 1'b0; ci1 = 1'b0; v1 = 1'b1;
        tick();
        check("hold_load", 64'({c1, s1, ov1}), 64'b011);
        v1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            {a1, b1, ci1} = 3'($urandom_range(0, 7));
            tick();
            check($sformatf("hold_%0d", k), 64'({c1, s1, ov1}), 64'b010);
        end

        // Wide wrap-around and carry-in across all bits
        a4 = 4'hF; b4 = 4'h1; ci4 = 1'b0; v4 = 1'b1;
        tick();
        check("w4_wrap", 64'({c4, s4}), 64'h10);
        a4 = 4'hF; b4 = 4'h0; ci4 = 1'b1;
        tick();
        check("w4_cin_ripple", 64'({c4, s4}), 64'h10);
        a4 = 4'h3; b4 = 4'h4; ci4 = 1'b0;
        tick();
        check("w4_no_carry", 64'({c4, s4}), 64'h07);
        v4 = 1'b0;

        // 8-bit directed then random back-to-back
        a8 = 8'h7F; b8 = 8'h80; ci8 = 1'b1; v8 = 1'b1;
        tick();
        check("w8_full_ripple", 64'({c8, s8}), 64'h100);
        check("w8_valid", 64'(ov8), 64'd1);
        for (int n = 0; n < 1000; n++) begin
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            ci8 = 1'($urandom);
            tick();
        end
        v8 = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_full_adder_unit
